pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 114 +++++++++++
 tb/tb_pattern_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Steps a pattern-buffer pointer on PWM rising edges for a programmed number of passes,
// and arbitrates host field writes so the buffer currently being played is never written.
module pattern_sequencer #(
  parameter int BUF_SIZE  = 12,
  parameter int BUF_WIDTH = 8,
  parameter int NO_BUFS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm,
  input  logic                 start,
  input  logic                 stop,
  input  logic [2:0]           seq_last,
  input  logic [7:0]           repeat_cnt,
  input  logic                 wr_req,
  input  logic [2:0]           wr_buf,
  input  logic [BUF_SIZE-1:0]  wr_field,
  input  logic [BUF_WIDTH-1:0] wr_data,
  input  logic [BUF_SIZE-1:0]  rd_field,
  output logic                 wr_ack,
  output logic [2:0]           bufp,
  output logic [BUF_SIZE-1:0]  fieldp,
  output logic [BUF_SIZE-1:0]  fieldwp,
  output logic [BUF_WIDTH-1:0] field_in,
  output logic                 field_write,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] MAX_BUF = 3'(NO_BUFS - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FINISH} state_t;

  state_t     state_q, state_d;
  logic [2:0] bufp_d, last_eff;
  logic [7:0] pass_q, pass_d, pass_inc;
  logic       pwm_q, step, wr_accept;

  assign step      = pwm & ~pwm_q;
  assign last_eff  = (seq_last > MAX_BUF) ? MAX_BUF : seq_last;
  // Saturates so a free-running sequence never wraps back onto repeat_cnt.
  assign pass_inc  = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
  assign busy      = (state_q == ARM) || (state_q == RUN);
  assign done      = (state_q == FINISH);
  // Decision uses the registered (pre-step) bufp; wr_ack high blocks a second accept.
  assign wr_accept = wr_req & ~wr_ack & (~busy | (wr_buf != bufp));

  always_comb begin
    state_d = state_q;
    bufp_d  = bufp;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = ARM;
          bufp_d  = 3'd0;
          pass_d  = 8'd0;
        end
      end
      ARM: begin
        if (stop)      state_d = FINISH;
        else if (step) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = FINISH;
        end else if (step) begin
          if (bufp < last_eff) begin
            bufp_d = bufp + 3'd1;
          end else begin
            bufp_d = 3'd0;
            pass_d = pass_inc;
            if ((repeat_cnt != 8'd0) && (pass_inc == repeat_cnt)) state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bufp    <= 3'd0;
      pass_q  <= 8'd0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bufp    <= bufp_d;
      pass_q  <= pass_d;
      pwm_q   <= pwm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack      <= 1'b0;
      field_write <= 1'b0;
      fieldwp     <= '0;
      field_in    <= '0;
      fieldp      <= '0;
    end else begin
      wr_ack      <= wr_accept;
      field_write <= wr_accept;
      fieldp      <= rd_field;
      if (wr_accept) begin
        fieldwp  <= wr_field;
        field_in <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: vector table, directed corner sequences, then random
// traffic checked against a step-count model of the sequence and write arbiter.
module tb_pattern_sequencer;
  localparam int BS = 12;
  localparam int BW = 8;

  logic          clk = 1'b0, rst_n = 1'b1, pwm = 1'b0, start = 1'b0, stop = 1'b0;
  logic [2:0]    seq_last = 3'd0, wr_buf = 3'd0;
  logic [7:0]    repeat_cnt = 8'd0;
  logic          wr_req = 1'b0;
  logic [BS-1:0] wr_field = '0, rd_field = '0;
  logic [BW-1:0] wr_data = '0;
  logic          wr_ack, field_write, busy, done;
  logic [2:0]    bufp;
  logic [BS-1:0] fieldp, fieldwp;
  logic [BW-1:0] field_in;

  int n_chk = 0, n_fail = 0;

  pattern_sequencer #(.BUF_SIZE(BS), .BUF_WIDTH(BW), .NO_BUFS(8)) dut (
    .clk(clk), .rst_n(rst_n), .pwm(pwm), .start(start), .stop(stop),
    .seq_last(seq_last), .repeat_cnt(repeat_cnt), .wr_req(wr_req), .wr_buf(wr_buf),
    .wr_field(wr_field), .wr_data(wr_data), .rd_field(rd_field), .wr_ack(wr_ack),
    .bufp(bufp), .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
    .field_write(field_write), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pwm_edge();
    pwm = 1'b1; tick();
    pwm = 1'b0; tick();
  endtask

  task automatic start_run(input logic [2:0] last, input logic [7:0] rep);
    seq_last = last; repeat_cnt = rep;
    start = 1'b1; tick();
    start = 1'b0;
    pwm_edge();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pwm = 1'b0; start = 1'b0; stop = 1'b0; wr_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bufp"}, 32'(bufp), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ack"}, 32'(wr_ack), 0);
    chk({tag, "_fwrite"}, 32'(field_write), 0);
    chk({tag, "_fieldwp"}, 32'(fieldwp), 0);
    chk({tag, "_field_in"}, 32'(field_in), 0);
    chk({tag, "_fieldp"}, 32'(fieldp), 0);
  endtask

  // Reference model: position in the sequence is derived from the count of steps taken.
  int            m_mode;   // 0 idle, 1 armed, 2 running, 3 finishing
  int            m_steps, m_last, m_rep;
  logic [2:0]    m_bufp;
  logic          m_pwm_q, m_ack;
  logic [BS-1:0] m_fwp, m_fieldp;
  logic [BW-1:0] m_fin;

  task automatic model_update();
    logic acc, edge_seen, m_busy;
    m_busy = (m_mode == 1) || (m_mode == 2);
    acc = wr_req && !m_ack && (!m_busy || (wr_buf != m_bufp));
    m_ack = acc;
    if (acc) begin m_fwp = wr_field; m_fin = wr_data; end
    m_fieldp = rd_field;
    edge_seen = pwm && !m_pwm_q;
    m_pwm_q = pwm;
    case (m_mode)
      0: if (start && !stop) begin
           m_mode = 1; m_steps = 0; m_bufp = 3'd0;
           m_last = int'(seq_last); m_rep = int'(repeat_cnt);
         end
      1: if (stop) m_mode = 3; else if (edge_seen) m_mode = 2;
      2: if (stop) m_mode = 3;
         else if (edge_seen) begin
           m_steps++;
           m_bufp = 3'(m_steps % (m_last + 1));
           if (m_rep != 0 && m_steps == m_rep * (m_last + 1)) m_mode = 3;
         end
      default: m_mode = 0;
    endcase
  endtask

  typedef struct {
    bit       start, stop, pwm;
    bit [2:0] bufp;
    bit       busy, done;
  } vec_t;
  vec_t tbl [17];

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0}
    };

    // Asynchronous reset, observed before the first clock edge.
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Two passes over buffers 0..2; also start-in-RUN, start+stop in IDLE, stop in IDLE.
    seq_last = 3'd2; repeat_cnt = 8'd2;
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; pwm = tbl[i].pwm;
      tick();
      chk($sformatf("tbl%0d_bufp", i), 32'(bufp), 32'(tbl[i].bufp));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
    end
    start = 1'b0; stop = 1'b0; pwm = 1'b0;
    tick();

    // Free-running: 20 edges over 8 buffers, never done.
    seq_last = 3'd7; repeat_cnt = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pwm = 1'b1; tick();
      chk($sformatf("free%0d_bufp", k), 32'(bufp), 32'(k % 8));
      chk("free_busy", 32'(busy), 1);
      pwm = 1'b0; tick();
      chk("free_done", 32'(done), 0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("free_stop_done", 32'(done), 1);
    chk("free_stop_bufp", 32'(bufp), 3);
    tick();

    // Stop at bufp 5.
    start_run(3'd7, 8'd0);
    repeat (5) pwm_edge();
    chk("stop5_pre_bufp", 32'(bufp), 5);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop5_bufp", 32'(bufp), 5);
    chk("stop5_busy", 32'(busy), 0);
    chk("stop5_done", 32'(done), 1);
    tick();
    chk("stop5_done_clr", 32'(done), 0);
    chk("stop5_bufp_hold", 32'(bufp), 5);

    // Write to the active buffer stalls until the pointer steps away.
    start_run(3'd7, 8'd0);
    repeat (3) pwm_edge();
    wr_req = 1'b1; wr_buf = 3'd3; wr_field = 12'h5A5; wr_data = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_ack", 32'(wr_ack), 0);
      chk("stall_fwrite", 32'(field_write), 0);
    end
    pwm = 1'b1; tick();
    chk("stall_step_bufp", 32'(bufp), 4);
    chk("stall_step_ack", 32'(wr_ack), 0);
    pwm = 1'b0; tick();
    chk("stall_ack_go", 32'(wr_ack), 1);
    chk("stall_fwrite_go", 32'(field_write), 1);
    chk("stall_fieldwp", 32'(fieldwp), 32'h5A5);
    chk("stall_field_in", 32'(field_in), 32'hC3);
    wr_req = 1'b0; tick();
    chk("stall_ack_clr", 32'(wr_ack), 0);
    chk("stall_fwrite_clr", 32'(field_write), 0);
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Held request to a non-active buffer: acks on alternate cycles.
    start_run(3'd7, 8'd0);
    wr_req = 1'b1; wr_buf = 3'd2; wr_field = 12'h123; wr_data = 8'h45;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("b2b%0d_ack", k), 32'(wr_ack), 32'((k % 2) == 0));
    end
    wr_req = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Reset mid-run with a stalled write pending.
    rd_field = 12'hABC;
    start_run(3'd7, 8'd0);
    repeat (3) pwm_edge();
    wr_req = 1'b1; wr_buf = 3'd3; wr_field = 12'h777; wr_data = 8'h99;
    tick();
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    wr_req = 1'b0; rd_field = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("postrst_ack", 32'(wr_ack), 0);
      chk("postrst_done", 32'(done), 0);
      chk("postrst_busy", 32'(busy), 0);
    end

    // Random traffic against the model.
    do_reset();
    m_mode = 0; m_steps = 0; m_last = 0; m_rep = 0; m_bufp = 3'd0;
    m_pwm_q = 1'b0; m_ack = 1'b0; m_fwp = '0; m_fin = '0; m_fieldp = '0;
    for (int c = 0; c < 2500; c++) begin
      if (m_ack) wr_req = 1'b0;
      if (!wr_req && ($urandom % 4) == 0) begin
        wr_req   = 1'b1;
        wr_buf   = 3'($urandom_range(7));
        wr_field = BS'($urandom);
        wr_data  = BW'($urandom);
      end
      rd_field = BS'($urandom);
      if (m_mode == 0 && ($urandom % 8) == 0) begin
        seq_last   = 3'($urandom_range(7));
        repeat_cnt = 8'($urandom_range(3));
      end
      start = (($urandom % 8) == 0);
      stop  = (($urandom % 50) == 0);
      if (($urandom % 3) == 0) pwm = ~pwm;
      model_update();
      tick();
      chk("rnd_bufp", 32'(bufp), 32'(m_bufp));
      chk("rnd_busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
      chk("rnd_done", 32'(done), 32'(m_mode == 3));
      chk("rnd_ack", 32'(wr_ack), 32'(m_ack));
      chk("rnd_fwrite", 32'(field_write), 32'(m_ack));
      chk("rnd_fieldwp", 32'(fieldwp), 32'(m_fwp));
      chk("rnd_field_in", 32'(field_in), 32'(m_fin));
      chk("rnd_fieldp", 32'(fieldp), 32'(m_fieldp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
